// File: rtl/mdu_scheduler.sv
// Multi-cycle multiply/divide scheduler that owns HI/LO and stalls D-stage MD instructions.
// Optional macro MDU_EARLY_DONE_EN: zero-operand multiplies and divide-by-zero finish in one cycle.

module mdu_scheduler_chk (
  input logic       clk,
  input logic       reset,
  input logic       busy,
  input logic       start,
  input logic [2:0] md_op
);

  // The stall should keep MD ops out of E while busy; any that slip through are dropped.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && start && md_op >= 3'b001 && md_op <= 3'b110))
        else $warning("mdu_scheduler: start while busy ignored (md_op=%0d)", md_op);
    end
  end

endmodule

module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_r;
  logic [CW-1:0] counter_r;
  logic [CW-1:0] latency_r;
  logic [2:0]    op_r;
  logic [31:0]   opA_r;
  logic [31:0]   opB_r;

  logic          isMulDiv_s;
  logic [CW-1:0] startLatency_s;
  logic [63:0]   mulA_s;
  logic [63:0]   mulB_s;
  logic [63:0]   result_s;
  logic          writeResult_s;

  // Decode the E-stage op and pick the latency this operation will run for.
  always_comb begin
    isMulDiv_s     = 1'b0;
    startLatency_s = CW'(MULT_CYCLES);
    case (md_op)
      3'b001, 3'b010: begin
        isMulDiv_s = 1'b1;
`ifdef MDU_EARLY_DONE_EN
        if (rs_val == 32'h0 || rt_val == 32'h0) startLatency_s = CW'(1);
        else startLatency_s = CW'(MULT_CYCLES);
`else
        startLatency_s = CW'(MULT_CYCLES);
`endif
      end
      3'b011, 3'b100: begin
        isMulDiv_s = 1'b1;
`ifdef MDU_EARLY_DONE_EN
        if (rt_val == 32'h0) startLatency_s = CW'(1);
        else startLatency_s = CW'(DIV_CYCLES);
`else
        startLatency_s = CW'(DIV_CYCLES);
`endif
      end
      default: begin
        isMulDiv_s     = 1'b0;
        startLatency_s = CW'(MULT_CYCLES);
      end
    endcase
  end

  assign stall = d_is_md & (busy | (start & isMulDiv_s));

  // Result from the latched operands; a zero divisor leaves HI/LO untouched.
  always_comb begin
    mulA_s        = {{32{opA_r[31]}}, opA_r};
    mulB_s        = {{32{opB_r[31]}}, opB_r};
    result_s      = 64'h0;
    writeResult_s = 1'b1;
    case (op_r)
      3'b001: result_s = $signed(mulA_s) * $signed(mulB_s);
      3'b010: result_s = {32'h0, opA_r} * {32'h0, opB_r};
      3'b011: begin
        writeResult_s = (opB_r != 32'h0);
        result_s      = {$signed(opA_r) % $signed(opB_r), $signed(opA_r) / $signed(opB_r)};
      end
      3'b100: begin
        writeResult_s = (opB_r != 32'h0);
        result_s      = {opA_r % opB_r, opA_r / opB_r};
      end
      default: begin
        result_s      = 64'h0;
        writeResult_s = 1'b0;
      end
    endcase
  end

  // Busy/idle sequencer; also handles mthi/mtlo writes while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= {CW{1'b0}};
      latency_r <= {CW{1'b0}};
      op_r      <= 3'b000;
      opA_r     <= 32'h0;
      opB_r     <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= 32'h0;
      lo        <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          done      <= 1'b0;
          counter_r <= {CW{1'b0}};
          if (start && isMulDiv_s) begin
            op_r      <= md_op;
            opA_r     <= rs_val;
            opB_r     <= rt_val;
            latency_r <= startLatency_s;
            counter_r <= CW'(1);
            busy      <= 1'b1;
            state_r   <= RUN;
          end else if (start && md_op == 3'b101) begin
            hi <= rs_val;
          end else if (start && md_op == 3'b110) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (counter_r == latency_r) begin
            if (writeResult_s) begin
              hi <= result_s[63:32];
              lo <= result_s[31:0];
            end
            busy      <= 1'b0;
            done      <= 1'b1;
            counter_r <= {CW{1'b0}};
            state_r   <= IDLE;
          end else begin
            counter_r <= counter_r + CW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          counter_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  mdu_scheduler_chk uChk (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .start (start),
    .md_op (md_op)
  );

endmodule
